// File: rtl/bitser_pkg.sv
// Shared types and constants for the bit-serial operand path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bitser_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_shift.sv
// W-bit parallel-in serial-out register, shifts right and presents the LSB.
// Latency: loaded word's bit 0 appears the cycle after load, one bit per shift.
// Backpressure: none; the parent decides when to load and shift.
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W-1:0] sreg;

    // Load has priority over shift; zeros fill from the top so the register
    // drains to all-zero after the last bit, which keeps the idle output at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= din;
        end else if (shift) begin
            sreg <= {1'b0, sreg[W-1:1]};
        end
    end

    assign dout = sreg[0];

endmodule

// File: rtl/operand_serializer.sv
// Serializes an accepted A/B operand pair LSB first, with sync marking bit 0.
// Latency: bit 0 is on a/b one cycle after acceptance; W cycles per word.
// Backpressure: in_ready low while shifting (optionally high on the last bit
// when OPERAND_SERIALIZER_B2B_EN is defined, allowing gapless words).
module operand_serializer
    import bitser_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         a,
    output logic         b,
    output logic         sync
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

`ifdef OPERAND_SERIALIZER_B2B_EN
    localparam logic B2B = 1'b1;
`else
    localparam logic B2B = 1'b0;
`endif

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          accept;
    logic          last_bit;
    logic          sync_q;

    // State and bit counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, bit count and handshake; ready is forced low during reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_bit  = (state == SHIFT) && (cnt == LAST);
        in_ready  = 1'b0;
        if (rst_n) begin
            in_ready = (state == IDLE) || (B2B && last_bit);
        end
        accept = in_valid && in_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = accept ? SHIFT : IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Bit-0 marker: registered copy of the acceptance strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= accept;
        end
    end

    piso_shift #(.W(W)) u_shift_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (state == SHIFT),
        .din   (in_a),
        .dout  (a)
    );

    piso_shift #(.W(W)) u_shift_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (state == SHIFT),
        .din   (in_b),
        .dout  (b)
    );

    assign sync = sync_q;

endmodule

// File: tb/tb_operand_serializer.sv
// Directed bench for operand_serializer at W=8, with a bit-serial adder model.
// Latency: checks bit 0 one cycle after acceptance, sum one cycle behind.
// Backpressure: exercises hold-off, back-to-back and reset mid-word.
module tb_operand_serializer;

    localparam int W = 8;

`ifdef OPERAND_SERIALIZER_B2B_EN
    localparam logic B2B = 1'b1;
    localparam int   GAP = 8;
`else
    localparam logic B2B = 1'b0;
    localparam int   GAP = 9;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         a;
    logic         b;
    logic         sync;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Bit-serial adder chained on the serial outputs; carry-in cleared on sync.
    logic s_q = 1'b0;
    logic c_q = 1'b0;

    operand_serializer #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .a        (a),
        .b        (b),
        .sync     (sync)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sync) begin
            s_q <= a ^ b;
            c_q <= a & b;
        end else begin
            s_q <= a ^ b ^ c_q;
            c_q <= (a & b) | (a & c_q) | (b & c_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_a"}, 32'(a), 32'd0);
        chk({tag, "_b"}, 32'(b), 32'd0);
        chk({tag, "_sync"}, 32'(sync), 32'd0);
    endtask

    // Called in the bit-0 cycle; returns one cycle after the last bit.
    task automatic chk_word(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb);
        for (int i = 0; i < W; i++) begin
            chk({tag, "_a"}, 32'(a), 32'(ea[i]));
            chk({tag, "_b"}, 32'(b), 32'(eb[i]));
            chk({tag, "_sync"}, 32'(sync), (i == 0) ? 32'd1 : 32'd0);
            chk({tag, "_rdy"}, 32'(in_ready), (i == W - 1) ? 32'(B2B) : 32'd0);
            step();
        end
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_sum);
        logic [W-1:0] sum;
        sum = '0;
        in_a = x;
        in_b = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_sync"}, 32'(sync), 32'd1);
        for (int k = 0; k < W; k++) begin
            step();
            sum[k] = s_q;
        end
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int t1;
        int t2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        step();
        step();
        chk_idle("rst");
        chk("rst_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);

        // Single word 0x5A / 0x3C.
        in_a = 8'h5A;
        in_b = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_word("w1", 8'h5A, 8'h3C);
        chk_idle("w1_end");
        chk("w1_end_rdy", 32'(in_ready), 32'd1);
        step();

        // Back-to-back with in_valid held; inputs change mid-word (hold-off).
        in_a = 8'hA5;
        in_b = 8'h0F;
        in_valid = 1'b1;
        step();
        t1 = cyc;
        in_a = 8'hC3;
        in_b = 8'h81;
        chk_word("b2b1", 8'hA5, 8'h0F);
        if (!B2B) begin
            chk_idle("gap");
            chk("gap_rdy", 32'(in_ready), 32'd1);
            step();
        end
        t2 = cyc;
        in_valid = 1'b0;
        chk("sync_dist", 32'(t2 - t1), 32'(GAP));
        chk_word("b2b2", 8'hC3, 8'h81);
        chk_idle("b2b_end");
        step();

        // Reset mid-word at cnt=3, with in_valid high across the reset edge.
        in_a = 8'h5A;
        in_b = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("cnt3_a", 32'(a), 32'd1);
        chk("cnt3_b", 32'(b), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        chk("rstlo_rdy", 32'(in_ready), 32'd0);
        step();
        chk_idle("rst_mid");
        chk("rst_mid_rdy", 32'(in_ready), 32'd0);
        step();
        chk_idle("rst_hold");
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_rel_rdy", 32'(in_ready), 32'd1);
        step();
        chk_idle("post_rst");
        in_a = 8'h96;
        in_b = 8'h69;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_word("restart", 8'h96, 8'h69);
        step();

        // Chained serial adder.
        run_add("add_ff_01", 8'hFF, 8'h01, 8'h00);
        step();
        run_add("add_0f_01", 8'h0F, 8'h01, 8'h10);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/operand_serializer.md
OPERAND_SERIALIZER -- requirements
Module: operand_serializer

Interface
REQ-001 SHALL have parameter W, default 8, operand word width in bits; legal range W >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  parallel operand pair available.
REQ-005 SHALL have port in_ready  output  1  serializer can accept an operand pair this cycle.
REQ-006 SHALL have port in_a  input  W  operand A, parallel.
REQ-007 SHALL have port in_b  input  W  operand B, parallel.
REQ-008 SHALL have port a  output  1  serial operand A bit, LSB first, registered.
REQ-009 SHALL have port b  output  1  serial operand B bit, LSB first, registered.
REQ-010 SHALL have port sync  output  1  high exactly during the bit-0 cycle of each word, registered.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT, plus a bit counter cnt of width clog2(W).
REQ-012 SHALL accept a word on a rising edge where in_valid && in_ready; in_a/in_b are sampled only then.
REQ-013 SHALL, in the cycle after acceptance, drive a=in_a[0], b=in_b[0], sync=1, enter SHIFT with cnt=0.
REQ-014 SHALL, for cnt=1..W-1, drive a=in_a[cnt], b=in_b[cnt], sync=0; one bit per clock, no stalls.
REQ-015 SHALL, after the cnt=W-1 cycle, return to IDLE unless a new word is accepted on that edge (see REQ-021).
REQ-016 SHALL hold a=0, b=0, sync=0 in IDLE.
REQ-017 SHALL drive in_ready=1 in IDLE and 0 during SHIFT cycles with cnt<W-1.
REQ-018 SHALL ignore in_valid while in_ready=0; in_a/in_b changes mid-word SHALL NOT affect the serial output.
REQ-019 SHALL produce exactly W serial cycles per accepted word; sync pulses of consecutive words are at least W cycles apart.

Reset
REQ-020 SHALL, on a rising edge with rst_n=0 (including mid-word), abort any word and set state=IDLE, cnt=0, a=0, b=0, sync=0; in_ready SHALL be 0 while rst_n=0 and no word SHALL be accepted on a reset edge.

Configuration
REQ-021 SHALL honour macro OPERAND_SERIALIZER_B2B_EN: when defined, in_ready=1 also in the cnt=W-1 cycle, and a word accepted there starts (sync=1, bit 0) on the very next cycle with no gap; when undefined, in_ready=0 for the whole SHIFT state, giving at least one IDLE cycle (a=b=sync=0) between words.

Structure
REQ-022 SHALL place the state enum (IDLE, SHIFT) and the default width constant in shared package bitser_pkg.
REQ-023 SHALL use one sub-module piso_shift (W-bit load/shift-right register, LSB out), instantiated once for A and once for B.

Verification (W=8)
REQ-024 SHALL test single word: in_a=0x5A, in_b=0x3C accepted -> a=0,1,0,1,1,0,1,0; b=0,0,1,1,1,1,0,0; sync=1 on first cycle only; IDLE after.
REQ-025 SHALL test back-to-back: in_valid held high with two words -> sync pulses 8 cycles apart with B2B_EN, 9 apart without, one all-zero gap cycle.
REQ-026 SHALL test reset mid-word: rst_n=0 at cnt=3 -> next cycle a=b=sync=0, in_ready=0 while low, 1 after release; new word restarts with sync.
REQ-027 SHALL test input hold-off: in_valid=1 with changing in_a during SHIFT -> no acceptance, serial stream of original word unchanged.
REQ-028 SHALL test chained with bit-serial adder: 0xFF+0x01 -> adder sum stream 0x00 (8 zero bits), delayed one cycle; 0x0F+0x01 -> 0x10.
